fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the fixed PC/fetch-latch pair at the front of the CPU pipeline. It owns the program counter, drives the instruction-memory address, and buffers fetched instruction/PC pairs in a DEPTH-entry prefetch FIFO. The FIFO decouples fetch from decode through a valid/ready handshake. Branch/jump redirects from later stages reload the PC and flush all buffered entries.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// buffers fetched {pc, instr} pairs in a DEPTH-entry prefetch FIFO toward decode.
module fetch_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PC_INC      = 1,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_data,
  input  logic                       imem_ready,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [PW-1:0]          head_next;
  logic [CW-1:0]          count;
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   deq;
  logic                   enq;

  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign out_valid  = (count != '0);
  assign out_pc     = pc_q;
  assign out_instr  = instr_q;

  assign deq       = out_valid && out_ready;
  assign enq       = imem_ready && !redirect && ((count < CW'(DEPTH)) || deq);
  assign head_next = head + PW'(1);

  // The head is mirrored in an output register so out_* hold their last value
  // when the FIFO drains. Next head: the following stored entry, or the word
  // being fetched this cycle if it will be the only entry.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (!redirect) begin
      if (deq) begin
        if (count > CW'(1)) begin
          pc_d    = pc_mem[head_next];
          instr_d = instr_mem[head_next];
        end else if (enq) begin
          pc_d    = fetch_pc;
          instr_d = imem_data;
        end
      end else if (count == '0 && enq) begin
        pc_d    = fetch_pc;
        instr_d = imem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= PC_WIDTH'(RESET_PC);
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (enq) begin
          fetch_pc <= fetch_pc + PC_WIDTH'(PC_INC);
          tail     <= tail + PW'(1);
        end
        if (deq) head <= head_next;
        if (enq && !deq)      count <= count + CW'(1);
        else if (deq && !enq) count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word equals its address, so out_instr
// must always track out_pc.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [2:0]  fifo_count;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'(imem_addr);

  fetch_unit #(
    .PC_WIDTH(8), .INSTR_WIDTH(32), .DEPTH(4), .PC_INC(1), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] pc,
                         input logic [2:0] cnt);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".pc"}, 32'(out_pc), 32'(pc));
    chk({tag, ".instr"}, out_instr, 32'(pc));
    chk({tag, ".count"}, 32'(fifo_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    #2;
    chk_out("reset", 1'b0, 8'h00, 3'd0);
    chk("reset.addr", 32'(imem_addr), 32'h0);
    tick(); tick();
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b1; out_ready = 1'b1;

    // Streaming: one instruction per cycle after 1-cycle latency
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("stream", 1'b1, 8'(k), 3'd1);
    end
    chk("stream.addr", 32'(imem_addr), 32'h4);

    // Backpressure: head 3 stays, entries 4,5,6 fill behind it
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("bp.pc", 32'(out_pc), 32'h3);
    end
    chk("bp.count", 32'(fifo_count), 32'h4);
    chk("bp.addr", 32'(imem_addr), 32'h7);

    // Full with simultaneous dequeue: count stays 4, one enqueue per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("full_deq", 1'b1, 8'(4 + k), 3'd4);
      chk("full_deq.addr", 32'(imem_addr), 32'(8 + k));
    end

    // Redirect together with a dequeue of head 6
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    chk("redir.valid", 32'(out_valid), 32'h0);
    chk("redir.count", 32'(fifo_count), 32'h0);
    chk("redir.addr", 32'(imem_addr), 32'h40);
    tick();
    chk_out("redir1", 1'b1, 8'h40, 3'd1);
    tick();
    chk_out("redir2", 1'b1, 8'h41, 3'd1);

    // Wrap through FF->00 with a one-cycle memory wait
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    chk("wrap.addr0", 32'(imem_addr), 32'hFE);
    tick();
    chk_out("wrapFE", 1'b1, 8'hFE, 3'd1);
    imem_ready = 1'b0;
    tick();
    chk("wait.valid", 32'(out_valid), 32'h0);
    chk("wait.addr", 32'(imem_addr), 32'hFF);
    chk("wait.hold_pc", 32'(out_pc), 32'hFE);
    imem_ready = 1'b1;
    tick();
    chk_out("wrapFF", 1'b1, 8'hFF, 3'd1);
    tick();
    chk_out("wrap00", 1'b1, 8'h00, 3'd1);
    tick();
    chk_out("wrap01", 1'b1, 8'h01, 3'd1);
    chk("wrap.addr", 32'(imem_addr), 32'h02);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk_out("areset", 1'b0, 8'h00, 3'd0);
    chk("areset.addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_out("restart0", 1'b1, 8'h00, 3'd1);
    tick();
    chk_out("restart1", 1'b1, 8'h01, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
